// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce front end: FSM encoding and default timing.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_fsm_e;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;
    localparam int unsigned PRESS_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reset level is configurable.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level, edge/long-press strobes and a press count.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_in,
    output logic                   key_state,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic                   long_pulse,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic key_raw;
    logic key_s;

    key_fsm_e               state_q, state_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d, deb_inc;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic                   key_state_q, key_state_d;
    logic                   press_pulse_q, press_pulse_d;
    logic                   release_pulse_q, release_pulse_d;
    logic                   long_pulse_q, long_pulse_d;

    // Synchroniser idles at the released pin level so reset never looks like a press
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_raw)
    );

    assign key_s = key_raw ^ ACTIVE_LOW;

    always_comb begin
        state_d         = state_q;
        deb_cnt_d       = deb_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        press_cnt_d     = press_cnt_q;
        key_state_d     = key_state_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        deb_inc         = deb_cnt_q + DEB_W'(1);

        // Hold time keeps running through release bounce; saturation stops long_pulse repeating
        if (state_q == HELD || state_q == RELEASE_CHK) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            long_pulse_d = (hold_cnt_q == HOLD_LAST);
        end

        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_d = IDLE;
                end else if (deb_inc == DEB_LAST) begin
                    state_d       = HELD;
                    key_state_d   = 1'b1;
                    press_pulse_d = 1'b1;
                    press_cnt_d   = press_cnt_q + PRESS_CNT_W'(1);
                    hold_cnt_d    = '0;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d   = RELEASE_CHK;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_CHK: begin
                if (key_s) begin
                    state_d = HELD;
                end else if (deb_inc == DEB_LAST) begin
                    state_d         = IDLE;
                    key_state_d     = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            deb_cnt_q       <= '0;
            hold_cnt_q      <= '0;
            press_cnt_q     <= '0;
            key_state_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            deb_cnt_q       <= deb_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            press_cnt_q     <= press_cnt_d;
            key_state_q     <= key_state_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
        end
    end

    assign key_state     = key_state_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign press_cnt     = press_cnt_q;

endmodule
